// File: rtl/dehaze_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// dehaze_frame_ctrl_if
// Pixel stream bundle carrying the pipelined dark-channel video into the
// frame controller.
//   i_dark  : 8-bit dark-channel value, meaningful while i_de is high
//   i_hsync : horizontal sync, aligned with i_dark
//   i_vsync : vertical sync, active high, aligned with i_dark
//   i_de    : data enable, aligned with i_dark
// Modports: master drives the stream, slave (the controller) receives it.
// -----------------------------------------------------------------------------
interface dehaze_frame_ctrl_if;
    logic [7:0] i_dark;
    logic       i_hsync;
    logic       i_vsync;
    logic       i_de;

    modport master (
        output i_dark,
        output i_hsync,
        output i_vsync,
        output i_de
    );

    modport slave (
        input  i_dark,
        input  i_hsync,
        input  i_vsync,
        input  i_de
    );
endinterface

// File: rtl/dehaze_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dehaze_frame_ctrl
// Frame-level controller for the dark-channel dehaze pipeline. Tracks the
// per-frame maximum dark value and, at every frame boundary, commits a
// smoothed and clamped atmospheric-light estimate, latches the bypass mode
// for the next frame and reports frame geometry.
//
// Ports:
//   pixelclk      : pixel clock, all logic on its rising edge
//   reset_n       : asynchronous active-low reset
//   pix           : dark-channel stream (slave side of dehaze_frame_ctrl_if)
//   cfg_enable    : controller enable, 0 forces IDLE
//   cfg_bypass    : requested bypass, sampled only at commit
//   cfg_a_min     : lower clamp for the committed estimate
//   o_atmos       : committed atmospheric light (reset 8'hFF)
//   o_atmos_valid : one-cycle pulse when o_atmos updates
//   o_bypass      : frame-latched bypass (reset 1)
//   o_width       : de-high pixels in the last line of the previous frame
//   o_height      : de-high lines in the previous frame
//   o_geom_err    : one-cycle pulse at commit when geometry changed
//   o_frame_cnt   : committed frame count, wraps
// -----------------------------------------------------------------------------
module dehaze_frame_ctrl #(
    parameter int PIX_W  = 12,
    parameter bit SMOOTH = 1'b1
) (
    input  logic                  pixelclk,
    input  logic                  reset_n,
    dehaze_frame_ctrl_if.slave    pix,
    input  logic                  cfg_enable,
    input  logic                  cfg_bypass,
    input  logic [7:0]            cfg_a_min,
    output logic [7:0]            o_atmos,
    output logic                  o_atmos_valid,
    output logic                  o_bypass,
    output logic [PIX_W-1:0]      o_width,
    output logic [PIX_W-1:0]      o_height,
    output logic                  o_geom_err,
    output logic [15:0]           o_frame_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Counters stick at all-ones instead of wrapping on oversized frames.
    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // 3*a_old + m peaks at 1020, so 10 bits hold it and >>2 fits back in 8.
    function automatic logic [7:0] estimate(input logic [7:0] a_old, input logic [7:0] m);
        logic [9:0] acc;
        acc = {2'b00, a_old} + {1'b0, a_old, 1'b0} + {2'b00, m};
        return SMOOTH ? acc[9:2] : m;
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             vsync_d;
    logic             de_d;
    logic [7:0]       frame_max;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] line_w;
    logic [PIX_W-1:0] line_cnt;
    logic             vsync_rise;
    logic             de_fall;
    logic             acc_clear;
    logic             unused_hsync;

    // Line boundaries come from de edges, so hsync carries no information here.
    assign unused_hsync = pix.i_hsync;

    assign vsync_rise = pix.i_vsync & ~vsync_d;
    assign de_fall    = ~pix.i_de & de_d;
    assign acc_clear  = (state == ST_IDLE) || (state == ST_COMMIT) ||
                        ((state == ST_SYNC) && (state_nxt == ST_ACTIVE));

    always_comb begin
        state_nxt = state;
        if (!cfg_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_SYNC;
                ST_SYNC:   if (vsync_rise) state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (vsync_rise) state_nxt = ST_COMMIT;
                default:   state_nxt = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            vsync_d <= 1'b0;
            de_d    <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= pix.i_vsync;
            de_d    <= pix.i_de;
        end
    end

    // Accumulation stage: per-frame statistics, only live in ACTIVE
    always_ff @(posedge pixelclk) begin
        if (acc_clear) begin
            frame_max <= 8'd0;
            pix_cnt   <= '0;
            line_w    <= '0;
            line_cnt  <= '0;
        end else if (state == ST_ACTIVE) begin
            if (pix.i_de) begin
                frame_max <= max8(frame_max, pix.i_dark);
                pix_cnt   <= sat_inc(pix_cnt);
            end
            if (de_fall) begin
                line_w   <= pix_cnt;
                pix_cnt  <= '0;
                line_cnt <= sat_inc(line_cnt);
            end
        end
    end

    // Commit stage: frame-stable outputs, updated only in the cycle after COMMIT
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_atmos       <= 8'hFF;
            o_atmos_valid <= 1'b0;
            o_bypass      <= 1'b1;
            o_width       <= '0;
            o_height      <= '0;
            o_geom_err    <= 1'b0;
            o_frame_cnt   <= 16'd0;
        end else begin
            o_atmos_valid <= 1'b0;
            o_geom_err    <= 1'b0;
            if ((state == ST_COMMIT) && cfg_enable) begin
                o_atmos       <= max8(estimate(o_atmos, frame_max), cfg_a_min);
                o_atmos_valid <= 1'b1;
                o_bypass      <= cfg_bypass;
                o_width       <= line_w;
                o_height      <= line_cnt;
                o_frame_cnt   <= o_frame_cnt + 16'd1;
                // The very first commit has nothing to compare against.
                o_geom_err    <= (o_frame_cnt != 16'd0) &&
                                 ((line_w != o_width) || (line_cnt != o_height));
            end
        end
    end

endmodule
